bram_arbiter: RTL and testbench
===============================

# bram_arbiter

Round-robin arbiter that shares one `BRAMLike` simple-dual-port memory (one write port, one read port, 1-cycle read latency, read-first) between `NUM_PORTS` requesters. Each cycle it grants at most one read and, independently, at most one write. It drives the memory ports combinationally and routes the registered read data back to the requester that issued the read. It sits between the core-side/host-side memory clients and the memory instance.

## Interface
- `DATA_WIDTH`, 16: memory word width.
- `ADDRESS_WIDTH`, 11: memory address width.
- `NUM_PORTS`, 2: number of requesters; legal values are 2..8.
- `clock`  in  1: sole clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_PORTS: per-requester request valid.
- `req_wen`  in  NUM_PORTS: per-requester request type; 1 = write, 0 = read.
- `req_addr`  in  NUM_PORTS*ADDRESS_WIDTH: request addresses; slice i belongs to port i.
- `req_wdata`  in  NUM_PORTS*DATA_WIDTH: write data; slice i belongs to port i.
- `req_ready`  out  NUM_PORTS: per-port request accepted this cycle.
- `resp_valid`  out  NUM_PORTS: per-port read data valid.
- `resp_rdata`  out  DATA_WIDTH: shared read data bus; it is meaningful only on the port whose `resp_valid` is high.
- `mem_raddr`  out  ADDRESS_WIDTH: to memory `raddr`.
- `mem_dout`  in  DATA_WIDTH: from memory `dout`.
- `mem_wen`  out  1: to memory `wen`.
- `mem_waddr`  out  ADDRESS_WIDTH: to memory `waddr`.
- `mem_din`  out  DATA_WIDTH: to memory `din`.

## Operation
- **Read candidates:** ports with `req_valid & ~req_wen`.
- **Write candidates:** ports with `req_valid & req_wen`.
- **Separate arbiters:** two independent round-robin arbiters, one for reads and one for writes, each with its own priority pointer `rptr`/`wptr` (width clog2(NUM_PORTS)).
- **Grant rule:** the winner is the first candidate found searching upward from the pointer, wrapping modulo NUM_PORTS.
- **Pointer update:**
  - On a grant, the pointer moves to winner+1, wrapping from NUM_PORTS-1 to 0.
  - With no grant, the pointer holds.
- **`req_ready`:** `req_ready[i]` is high only for the read winner or the write winner. It is a combinational function of `req_valid`, `req_wen` and the pointers.
- **Requester handshake rules:**
  - A requester must hold valid/wen/addr/wdata stable until ready.
  - `req_valid` must not depend on `req_ready`.
- **Write grant:**
  - `mem_wen` = 1.
  - `mem_waddr` and `mem_din` take the winner's address and data slices.
- **No write grant:**
  - `mem_wen` = 0.
  - `mem_waddr` and `mem_din` are 0.
- **Read grant:**
  - `mem_raddr` takes the winner's address.
  - Register `rsp_port` <= winner and `rsp_pend` <= 1.
- **No read grant:**
  - `mem_raddr` holds its last value, so there is no needless address toggling.
  - `rsp_pend` <= 0.
- **Response:**
  - `resp_valid[i]` = `rsp_pend & (rsp_port == i)`.
  - `resp_rdata` = `mem_dout`, passed through combinationally.
- **Same-cycle read and write to the same address:**
  - Both are granted.
  - The read returns the OLD contents (read-first).
  - The arbiter performs no forwarding.
- **Responses are not backpressurable:** a requester must accept `resp_valid` unconditionally.
- **Reset (asynchronous assert):**
  - `rptr` = 0, `wptr` = 0.
  - `rsp_pend` = 0, `rsp_port` = 0.
  - `mem_raddr` register = 0.
  - Hence `resp_valid` = 0.
  - Combinational outputs still follow their inputs during reset. Memory contents are not cleared.
- **Reset mid-operation:** a read granted in the cycle before reset produces no `resp_valid`.

## Timing
- **Grant latency:** 0 cycles. A request is granted in the same cycle it is presented if it wins.
- **Read latency:** a read accepted in cycle N has `resp_valid`/`resp_rdata` in cycle N+1.
- **Write latency:** a write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
- **Throughput:** one read plus one write per cycle, sustained. Back-to-back reads from the same port are allowed.
- **Fairness:** with all NUM_PORTS ports continuously requesting one type, each port is granted exactly once every NUM_PORTS cycles.

## Structure
- **Package `bram_arbiter_pkg`:**
  - default width constants.
  - a `clog2`-based port-index width function.
  - typedef `port_idx_t`.
- **Sub-module `rr_arbiter`:**
  - parameter NUM_PORTS.
  - ports: `clock`, `reset_n`, `req`, `gnt` (one-hot), `gnt_idx`, `gnt_valid`.
  - It owns its pointer register.
  - Instantiated twice: once for reads, once for writes.
- **Top level:** muxes the request slices and holds the response registers only.

## Test plan
- **Write then read, single port:** port0 writes addr 5 = 0xBEEF in cycle 0, then reads addr 5 in cycle 1 -> `resp_valid[0]` and `resp_rdata` = 0xBEEF in cycle 2.
- **Same-cycle hazard:** mem[7] = 0x1111. Port0 writes 0x2222 to addr 7 while port1 reads addr 7 in the same cycle -> next cycle `resp_valid[1]` with 0x1111. A later read returns 0x2222.
- **Fairness:** NUM_PORTS=4, all four ports issue continuous reads -> grants go 0,1,2,3,0,… and each `resp_valid[i]` appears exactly once every 4 cycles, one cycle after port i's grant.
- **Parallel read + write:** port0 reads addr 1 while port1 writes addr 2 in the same cycle -> both ports see `req_ready` = 1 in that cycle and `mem_wen` = 1.
- **Pointer behaviour on skip and idle:** only port1 requests a read, then a cycle with no requests, then ports 0 and 1 both request a read -> port0 wins, because after port1's grant the pointer is 0 (1+1 wrapped) and the idle cycle does not move it.
- **Reset abort:** port0 is granted a read in cycle N, `reset_n` goes low in cycle N+1 before the clock edge -> `resp_valid` = 0 immediately and stays 0. After release, both pointers are 0.

Source files
------------

// File: rtl/bram_arbiter_pkg.sv
// Shared constants, types and helpers for the BRAM round-robin arbiter.
package bram_arbiter_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH    = 16;
  localparam int unsigned DEFAULT_ADDRESS_WIDTH = 11;
  localparam int unsigned DEFAULT_NUM_PORTS     = 2;
  localparam int unsigned MAX_NUM_PORTS         = 8;

  // Index width able to hold the largest legal port number.
  localparam int unsigned PORT_IDX_MAX_W = 3;

  typedef logic [PORT_IDX_MAX_W-1:0] port_idx_t;

  // Bits needed to index n ports; never less than one bit.
  function automatic int unsigned port_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer.
module rr_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = DEFAULT_NUM_PORTS,
  localparam int unsigned IDX_W     = port_idx_w(NUM_PORTS)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_valid
);

  logic [IDX_W-1:0] r_ptr;

  // Search upward from the pointer, wrapping, and take the first request.
  always_comb begin
    int unsigned      v_sum;
    logic [IDX_W-1:0] v_idx;
    v_sum     = 0;
    v_idx     = '0;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      v_sum = 32'(r_ptr) + k;
      if (v_sum >= NUM_PORTS) begin
        v_sum = v_sum - NUM_PORTS;
      end
      v_idx = IDX_W'(v_sum);
      if (!gnt_valid && req[v_idx]) begin
        gnt_valid  = 1'b1;
        gnt_idx    = v_idx;
        gnt[v_idx] = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner; holds when nothing is granted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (gnt_valid) begin
      if (gnt_idx == IDX_W'(NUM_PORTS - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= gnt_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one simple-dual-port BRAM between NUM_PORTS requesters:
// one read and one write granted per cycle, read data routed back a cycle later.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter  int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter  int unsigned NUM_PORTS     = DEFAULT_NUM_PORTS,
  localparam int unsigned IDX_W         = port_idx_w(NUM_PORTS)
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [NUM_PORTS-1:0]               req_valid,
  input  logic [NUM_PORTS-1:0]               req_wen,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_PORTS-1:0]               req_ready,
  output logic [NUM_PORTS-1:0]               resp_valid,
  output logic [DATA_WIDTH-1:0]              resp_rdata,
  output logic [ADDRESS_WIDTH-1:0]           mem_raddr,
  input  logic [DATA_WIDTH-1:0]              mem_dout,
  output logic                               mem_wen,
  output logic [ADDRESS_WIDTH-1:0]           mem_waddr,
  output logic [DATA_WIDTH-1:0]              mem_din
);

  logic [ADDRESS_WIDTH-1:0] w_addr [NUM_PORTS];
  logic [DATA_WIDTH-1:0]    w_data [NUM_PORTS];

  logic [NUM_PORTS-1:0] w_rd_req;
  logic [NUM_PORTS-1:0] w_wr_req;
  logic [NUM_PORTS-1:0] w_rd_gnt;
  logic [NUM_PORTS-1:0] w_wr_gnt;
  logic [IDX_W-1:0]     w_rd_idx;
  logic [IDX_W-1:0]     w_wr_idx;
  logic                 w_rd_valid;
  logic                 w_wr_valid;

  logic [ADDRESS_WIDTH-1:0] r_raddr;
  logic                     r_rsp_pend;
  port_idx_t                r_rsp_port;

  // Unpack the flat request buses into per-port slices.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slice
    assign w_addr[g] = req_addr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign w_data[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_rd_req = req_valid & ~req_wen;
  assign w_wr_req = req_valid & req_wen;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rd_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (w_rd_req),
    .gnt       (w_rd_gnt),
    .gnt_idx   (w_rd_idx),
    .gnt_valid (w_rd_valid)
  );

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_wr_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (w_wr_req),
    .gnt       (w_wr_gnt),
    .gnt_idx   (w_wr_idx),
    .gnt_valid (w_wr_valid)
  );

  assign req_ready = w_rd_gnt | w_wr_gnt;

  // Memory port steering; read address holds when idle to avoid toggling.
  always_comb begin
    mem_wen   = w_wr_valid;
    mem_waddr = '0;
    mem_din   = '0;
    mem_raddr = r_raddr;
    if (w_wr_valid) begin
      mem_waddr = w_addr[w_wr_idx];
      mem_din   = w_data[w_wr_idx];
    end
    if (w_rd_valid) begin
      mem_raddr = w_addr[w_rd_idx];
    end
  end

  // Remember the read address and which port owns next cycle's read data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_raddr    <= '0;
      r_rsp_pend <= 1'b0;
      r_rsp_port <= '0;
    end else if (w_rd_valid) begin
      r_raddr    <= mem_raddr;
      r_rsp_pend <= 1'b1;
      r_rsp_port <= port_idx_t'(w_rd_idx);
    end else begin
      r_rsp_pend <= 1'b0;
    end
  end

  // Response strobe for the port that issued last cycle's read.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_resp
    assign resp_valid[g] = r_rsp_pend && (r_rsp_port == port_idx_t'(g));
  end

  assign resp_rdata = mem_dout;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter with four ports, a read-first BRAM and a reference model.
module tb_bram_arbiter;

  localparam int DW = 16;
  localparam int AW = 11;
  localparam int NP = 4;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [NP-1:0]    req_valid;
  logic [NP-1:0]    req_wen;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP-1:0]    req_ready;
  logic [NP-1:0]    resp_valid;
  logic [DW-1:0]    resp_rdata;
  logic [AW-1:0]    mem_raddr;
  logic [DW-1:0]    mem_dout;
  logic             mem_wen;
  logic [AW-1:0]    mem_waddr;
  logic [DW-1:0]    mem_din;

  int n_checks = 0;
  int n_errors = 0;

  bram_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .NUM_PORTS     (NP)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_raddr  (mem_raddr),
    .mem_dout   (mem_dout),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_din    (mem_din)
  );

  always #5 clock = ~clock;

  // Read-first simple-dual-port memory.
  logic [DW-1:0] bram [2**AW];
  always @(posedge clock) begin
    if (mem_wen) bram[mem_waddr] <= mem_din;
    mem_dout <= bram[mem_raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [2**AW];
  int            m_rptr = 0;
  int            m_wptr = 0;
  bit            m_pend = 0;
  int            m_port = 0;
  logic [DW-1:0] m_pdata = '0;
  logic [AW-1:0] m_raddr = '0;

  function automatic int pick(input logic [NP-1:0] cand, input int ptr);
    for (int k = 0; k < NP; k++) begin
      if (cand[(ptr + k) % NP]) return (ptr + k) % NP;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int p);
    logic [NP*AW-1:0] v = req_addr;
    return v[p*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] data_of(input int p);
    logic [NP*DW-1:0] v = req_wdata;
    return v[p*DW +: DW];
  endfunction

  // Compare every cycle at the falling edge, then advance the model.
  always @(negedge clock) begin
    int            rw, ww;
    logic [NP-1:0] exp_ready;
    logic [NP-1:0] exp_resp;
    logic [AW-1:0] exp_raddr;
    if (!reset_n) begin
      m_rptr = 0; m_wptr = 0; m_pend = 0; m_port = 0; m_raddr = '0;
    end
    rw = pick(req_valid & ~req_wen, m_rptr);
    ww = pick(req_valid & req_wen, m_wptr);
    exp_ready = '0;
    if (rw >= 0) exp_ready[rw] = 1'b1;
    if (ww >= 0) exp_ready[ww] = 1'b1;
    exp_raddr = (rw >= 0) ? addr_of(rw) : m_raddr;
    exp_resp = '0;
    if (m_pend) exp_resp[m_port] = 1'b1;
    chk("m_ready", 32'(req_ready), 32'(exp_ready));
    chk("m_wen", 32'(mem_wen), 32'(ww >= 0));
    chk("m_waddr", 32'(mem_waddr), (ww >= 0) ? 32'(addr_of(ww)) : 32'd0);
    chk("m_din", 32'(mem_din), (ww >= 0) ? 32'(data_of(ww)) : 32'd0);
    chk("m_raddr", 32'(mem_raddr), 32'(exp_raddr));
    chk("m_resp_valid", 32'(resp_valid), 32'(exp_resp));
    if (m_pend) chk("m_rdata", 32'(resp_rdata), 32'(m_pdata));
    if (reset_n) begin
      if (rw >= 0) begin
        m_pend = 1; m_port = rw; m_pdata = ref_mem[exp_raddr];
        m_raddr = exp_raddr; m_rptr = (rw + 1) % NP;
      end else begin
        m_pend = 0;
      end
      if (ww >= 0) m_wptr = (ww + 1) % NP;
    end
    if (ww >= 0) ref_mem[addr_of(ww)] = data_of(ww);
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_in();
    req_valid = '0; req_wen = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic set_port(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[p] = 1'b1;
    req_wen[p]   = w;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*DW +: DW] = d;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      bram[i] = '0;
      ref_mem[i] = '0;
    end
    reset_n = 1'b0;
    clear_in();
    repeat (2) @(negedge clock);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_raddr", 32'(mem_raddr), 32'd0);
    next_cycle();
    reset_n = 1'b1;

    // Write then read on port0.
    clear_in(); set_port(0, 1, 11'd5, 16'hBEEF);
    @(negedge clock);
    chk("wr_ready", 32'(req_ready), 32'h1);
    chk("wr_wen", 32'(mem_wen), 32'h1);
    next_cycle();
    clear_in(); set_port(0, 0, 11'd5, 16'h0);
    @(negedge clock);
    chk("rd_ready", 32'(req_ready), 32'h1);
    next_cycle();
    clear_in();
    @(negedge clock);
    chk("rd_resp_valid", 32'(resp_valid), 32'h1);
    chk("rd_rdata", 32'(resp_rdata), 32'hBEEF);
    next_cycle();

    // Same-cycle read/write to addr 7 returns the old contents.
    clear_in(); set_port(0, 1, 11'd7, 16'h1111);
    next_cycle();
    clear_in(); set_port(0, 1, 11'd7, 16'h2222); set_port(1, 0, 11'd7, 16'h0);
    @(negedge clock);
    chk("haz_ready", 32'(req_ready), 32'h3);
    next_cycle();
    clear_in(); set_port(1, 0, 11'd7, 16'h0);
    @(negedge clock);
    chk("haz_resp_valid", 32'(resp_valid), 32'h2);
    chk("haz_old", 32'(resp_rdata), 32'h1111);
    next_cycle();
    clear_in();
    @(negedge clock);
    chk("haz_new", 32'(resp_rdata), 32'h2222);
    next_cycle();

    // Fairness: bring the read pointer to 0 via port3, then all read.
    for (int p = 0; p < NP; p++) begin
      clear_in(); set_port(p, 1, AW'(10 + p), DW'(16'hA000 + p));
      next_cycle();
    end
    clear_in(); set_port(3, 0, 11'd13, 16'h0);
    next_cycle();
    clear_in();
    for (int p = 0; p < NP; p++) set_port(p, 0, AW'(10 + p), 16'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("fair_grant", 32'(req_ready), 32'(1) << (k % NP));
      chk("fair_resp", 32'(resp_valid), 32'(1) << ((k + 3) % NP));
      chk("fair_rdata", 32'(resp_rdata), 32'hA000 + ((k + 3) % NP));
      next_cycle();
    end

    // Parallel read and write from different ports.
    clear_in(); set_port(0, 0, 11'd1, 16'h0); set_port(1, 1, 11'd2, 16'h3333);
    @(negedge clock);
    chk("par_ready", 32'(req_ready), 32'h3);
    chk("par_wen", 32'(mem_wen), 32'h1);
    chk("par_waddr", 32'(mem_waddr), 32'h2);
    next_cycle();

    // Pointer after a lone grant and an idle cycle.
    clear_in(); set_port(1, 0, 11'd2, 16'h0);
    next_cycle();
    clear_in();
    @(negedge clock);
    chk("idle_ready", 32'(req_ready), 32'h0);
    next_cycle();
    clear_in(); set_port(0, 0, 11'd3, 16'h0); set_port(1, 0, 11'd4, 16'h0);
    @(negedge clock);
    chk("skip_ready", 32'(req_ready), 32'h1);
    next_cycle();

    // Reset aborts an in-flight read response.
    clear_in(); set_port(0, 0, 11'd5, 16'h0);
    next_cycle();
    reset_n = 1'b0;
    clear_in();
    #1;
    chk("abort_immediate", 32'(resp_valid), 32'h0);
    @(negedge clock);
    chk("abort_negedge", 32'(resp_valid), 32'h0);
    next_cycle();
    reset_n = 1'b1;
    @(negedge clock);
    chk("abort_stays", 32'(resp_valid), 32'h0);
    next_cycle();
    for (int p = 0; p < NP; p++) set_port(p, 0, AW'(20 + p), 16'h0);
    @(negedge clock);
    chk("rptr_reset", 32'(req_ready), 32'h1);
    next_cycle();
    clear_in();
    for (int p = 0; p < NP; p++) set_port(p, 1, AW'(30 + p), DW'(16'h5000 + p));
    @(negedge clock);
    chk("wptr_reset", 32'(req_ready), 32'h1);
    next_cycle();

    clear_in();
    repeat (3) next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
